// File: rtl/is_uart_rx_ctrl.sv
// UART RX controller: baud strobe, parity check, FWFT frame FIFO, overrun flag.
// Optional error counters enabled by IS_UART_RX_CTRL_ERRCNT_EN.
module is_uart_rx_ctrl #(
   parameter int CLK_DIV    = 868,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [1:0]                    cfg_parity_i,
   input  logic                          clr_i,
   input  logic                          rxct_r_i,
   input  logic                          rx_data_en_i,
   input  logic [9:0]                    rx_data_t_i,
   output logic                          rx_ce_o,
   output logic [7:0]                    m_data_o,
   output logic                          m_perr_o,
   output logic                          m_ferr_o,
   output logic                          m_valid_o,
   input  logic                          m_ready_i,
`ifdef IS_UART_RX_CTRL_ERRCNT_EN
   output logic [15:0]                   perr_cnt_o,
   output logic [15:0]                   ferr_cnt_o,
   output logic [15:0]                   ovr_cnt_o,
`endif
   output logic [$clog2(FIFO_DEPTH):0]   fill_o,
   output logic                          ovr_o
);

   localparam int CW = $clog2(CLK_DIV);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int FW = PW + 1;
   localparam logic [CW-1:0] CNT_PRE = CW'(CLK_DIV / 2 - 1);
   localparam logic [CW-1:0] CNT_TOP = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [9:0]    mem_q [FIFO_DEPTH];
   logic [9:0]    mem_d [FIFO_DEPTH];
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [FW-1:0] fill_q, fill_d;
   logic          ovr_q, ovr_d;
   logic          perr, full, pop, push, drop;
   logic [9:0]    wr_entry, head;

   always_comb begin
      cnt_d = cnt_q - CW'(1);
      if (rxct_r_i)
         cnt_d = CNT_PRE;
      else if (cnt_q == '0)
         cnt_d = CNT_TOP;
   end

   // Strobe is gated in reset so nothing leaks out before the preset lands.
   assign rx_ce_o = ~rst_i & ~rxct_r_i & (cnt_q == '0);

   always_comb begin
      perr = 1'b0;
      unique case (cfg_parity_i)
         2'b00: perr = 1'b0;
         2'b01: perr = (^rx_data_t_i[7:0]) ^ rx_data_t_i[8];
         2'b10: perr = ~((^rx_data_t_i[7:0]) ^ rx_data_t_i[8]);
         2'b11: perr = rx_data_t_i[8];
         default: perr = 1'b0;
      endcase
   end

   assign wr_entry = {rx_data_t_i[7:0], perr, rx_data_t_i[9]};
   assign full     = (fill_q == FW'(FIFO_DEPTH));
   assign pop      = m_valid_o & m_ready_i & ~clr_i;
   assign push     = rx_data_en_i & ~clr_i & (~full | pop);
   assign drop     = rx_data_en_i & ~clr_i & full & ~pop;

   always_comb begin
      mem_d  = mem_q;
      wr_d   = wr_q;
      rd_d   = rd_q;
      fill_d = fill_q;
      ovr_d  = ovr_q;
      if (clr_i) begin
         wr_d   = '0;
         rd_d   = '0;
         fill_d = '0;
         ovr_d  = 1'b0;
      end else begin
         if (push) begin
            mem_d[wr_q] = wr_entry;
            wr_d        = wr_q + PW'(1);
         end
         if (pop)
            rd_d = rd_q + PW'(1);
         if (push & ~pop)
            fill_d = fill_q + FW'(1);
         else if (pop & ~push)
            fill_d = fill_q - FW'(1);
         if (drop)
            ovr_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q  <= CNT_PRE;
         wr_q   <= '0;
         rd_q   <= '0;
         fill_q <= '0;
         ovr_q  <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++)
            mem_q[i] <= '0;
      end else begin
         cnt_q  <= cnt_d;
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         fill_q <= fill_d;
         ovr_q  <= ovr_d;
         mem_q  <= mem_d;
      end
   end

   assign head      = mem_q[rd_q];
   assign m_data_o  = head[9:2];
   assign m_perr_o  = head[1];
   assign m_ferr_o  = head[0];
   assign m_valid_o = (fill_q != '0);
   assign fill_o    = fill_q;
   assign ovr_o     = ovr_q;

`ifdef IS_UART_RX_CTRL_ERRCNT_EN
   logic [15:0] perr_cnt_q, perr_cnt_d;
   logic [15:0] ferr_cnt_q, ferr_cnt_d;
   logic [15:0] ovr_cnt_q, ovr_cnt_d;
   logic        cap;

   // Counted at capture, so dropped frames still contribute.
   assign cap = rx_data_en_i & ~clr_i;

   always_comb begin
      perr_cnt_d = perr_cnt_q;
      ferr_cnt_d = ferr_cnt_q;
      ovr_cnt_d  = ovr_cnt_q;
      if (clr_i) begin
         perr_cnt_d = '0;
         ferr_cnt_d = '0;
         ovr_cnt_d  = '0;
      end else begin
         if (cap & perr & (perr_cnt_q != 16'hFFFF))
            perr_cnt_d = perr_cnt_q + 16'd1;
         if (cap & rx_data_t_i[9] & (ferr_cnt_q != 16'hFFFF))
            ferr_cnt_d = ferr_cnt_q + 16'd1;
         if (drop & (ovr_cnt_q != 16'hFFFF))
            ovr_cnt_d = ovr_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         perr_cnt_q <= '0;
         ferr_cnt_q <= '0;
         ovr_cnt_q  <= '0;
      end else begin
         perr_cnt_q <= perr_cnt_d;
         ferr_cnt_q <= ferr_cnt_d;
         ovr_cnt_q  <= ovr_cnt_d;
      end
   end

   assign perr_cnt_o = perr_cnt_q;
   assign ferr_cnt_o = ferr_cnt_q;
   assign ovr_cnt_o  = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_is_uart_rx_ctrl.sv
// Bench for is_uart_rx_ctrl: directed steps plus random traffic vs a queue model.
// Counter outputs are checked when IS_UART_RX_CTRL_ERRCNT_EN is defined.
module tb_is_uart_rx_ctrl;

   localparam int D     = 8;
   localparam int DEPTH = 4;
   localparam int H     = D / 2;

   logic       clk = 1'b0;
   logic       rst_i = 1'b1;
   logic [1:0] cfg_parity_i = 2'b00;
   logic       clr_i = 1'b0;
   logic       rxct_r_i = 1'b1;
   logic       rx_data_en_i = 1'b0;
   logic [9:0] rx_data_t_i = '0;
   logic       rx_ce_o;
   logic [7:0] m_data_o;
   logic       m_perr_o, m_ferr_o, m_valid_o;
   logic       m_ready_i = 1'b0;
   logic [2:0] fill_o;
   logic       ovr_o;
`ifdef IS_UART_RX_CTRL_ERRCNT_EN
   logic [15:0] perr_cnt_o, ferr_cnt_o, ovr_cnt_o;
   int          perr_c, ferr_c, ovr_c;
`endif

   is_uart_rx_ctrl #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_i(rst_i), .cfg_parity_i(cfg_parity_i),
      .clr_i(clr_i), .rxct_r_i(rxct_r_i), .rx_data_en_i(rx_data_en_i),
      .rx_data_t_i(rx_data_t_i), .rx_ce_o(rx_ce_o), .m_data_o(m_data_o),
      .m_perr_o(m_perr_o), .m_ferr_o(m_ferr_o), .m_valid_o(m_valid_o),
      .m_ready_i(m_ready_i),
`ifdef IS_UART_RX_CTRL_ERRCNT_EN
      .perr_cnt_o(perr_cnt_o), .ferr_cnt_o(ferr_cnt_o), .ovr_cnt_o(ovr_cnt_o),
`endif
      .fill_o(fill_o), .ovr_o(ovr_o)
   );

   always #5 clk = ~clk;

   int         n_chk = 0;
   int         n_fail = 0;
   logic [9:0] q[$];
   bit         ovr_m = 0;
   bit         known = 0;
   int         run = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit model_perr(input logic [1:0] mode,
                                     input logic [7:0] d, input logic p);
      int ones;
      ones = $countones({d, p});
      case (mode)
         2'd1:    return (ones % 2) == 1;
         2'd2:    return (ones % 2) == 0;
         2'd3:    return p == 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Check outputs mid-cycle, advance model with this cycle's inputs, cross edge.
   task automatic step();
      bit         exp_ce, pop, drop, pe;
      logic [9:0] e;
      #3;
      if (known) begin
         exp_ce = !rst_i && !rxct_r_i && (run + 1 >= H) &&
                  (((run + 1 - H) % D) == 0);
         chk("rx_ce", {31'd0, rx_ce_o}, {31'd0, exp_ce});
         chk("m_valid", {31'd0, m_valid_o}, (q.size() != 0) ? 1 : 0);
         chk("fill", {29'd0, fill_o}, q.size());
         chk("ovr", {31'd0, ovr_o}, {31'd0, ovr_m});
         if (q.size() != 0) begin
            chk("m_data", {24'd0, m_data_o}, {24'd0, q[0][9:2]});
            chk("m_perr", {31'd0, m_perr_o}, {31'd0, q[0][1]});
            chk("m_ferr", {31'd0, m_ferr_o}, {31'd0, q[0][0]});
         end
`ifdef IS_UART_RX_CTRL_ERRCNT_EN
         chk("perr_cnt", {16'd0, perr_cnt_o}, perr_c);
         chk("ferr_cnt", {16'd0, ferr_cnt_o}, ferr_c);
         chk("ovr_cnt", {16'd0, ovr_cnt_o}, ovr_c);
`endif
      end
      if (rst_i || rxct_r_i) run = 0;
      else run++;
      if (rst_i || clr_i) begin
         q.delete();
         ovr_m = 0;
         if (rst_i) known = 1;
`ifdef IS_UART_RX_CTRL_ERRCNT_EN
         perr_c = 0; ferr_c = 0; ovr_c = 0;
`endif
      end else begin
         pop  = (q.size() != 0) && m_ready_i;
         drop = rx_data_en_i && (q.size() == DEPTH) && !pop;
         pe   = model_perr(cfg_parity_i, rx_data_t_i[7:0], rx_data_t_i[8]);
         e    = {rx_data_t_i[7:0], pe, rx_data_t_i[9]};
`ifdef IS_UART_RX_CTRL_ERRCNT_EN
         if (rx_data_en_i && pe && perr_c < 65535) perr_c++;
         if (rx_data_en_i && rx_data_t_i[9] && ferr_c < 65535) ferr_c++;
         if (drop && ovr_c < 65535) ovr_c++;
`endif
         if (pop) void'(q.pop_front());
         if (rx_data_en_i && !drop) q.push_back(e);
         if (drop) ovr_m = 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic push(input logic [7:0] d, input logic p, input logic f);
      rx_data_en_i = 1'b1;
      rx_data_t_i  = {f, p, d};
      step();
      rx_data_en_i = 1'b0;
   endtask

   initial begin
      #1;
      rst_i = 1'b1;
      steps(3);
      rst_i = 1'b0;
      chk("rst_data", {24'd0, m_data_o}, 0);
      chk("rst_fill", {29'd0, fill_o}, 0);
      chk("rst_ce", {31'd0, rx_ce_o}, 0);

      rxct_r_i = 1'b0;
      steps(100);
      rxct_r_i = 1'b1;
      steps(10);
      rxct_r_i = 1'b0;
      steps(2);
      rxct_r_i = 1'b1;
      step();
      rxct_r_i = 1'b0;
      steps(10);
      rxct_r_i = 1'b1;
      step();

      cfg_parity_i = 2'b01;
      push(8'hA5, 1'b0, 1'b0);
      chk("even_ok_data", {24'd0, m_data_o}, 32'hA5);
      chk("even_ok_perr", {31'd0, m_perr_o}, 0);
      m_ready_i = 1'b1; step(); m_ready_i = 1'b0;
      push(8'hA5, 1'b1, 1'b0);
      chk("even_bad_perr", {31'd0, m_perr_o}, 1);
      m_ready_i = 1'b1; step(); m_ready_i = 1'b0;
      cfg_parity_i = 2'b10;
      push(8'h01, 1'b0, 1'b0);
      chk("odd_ok_perr", {31'd0, m_perr_o}, 0);
      m_ready_i = 1'b1; step(); m_ready_i = 1'b0;
      step();

      for (int i = 0; i < 5; i++) push(8'h10 + 8'(i), 1'b0, 1'b0);
      chk("ovr_fill", {29'd0, fill_o}, 4);
      chk("ovr_flag", {31'd0, ovr_o}, 1);
      m_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("ovr_read", {24'd0, m_data_o}, 32'h10 + i);
         step();
      end
      m_ready_i = 1'b0;
      chk("ovr_empty", {31'd0, m_valid_o}, 0);

      clr_i = 1'b1; step(); clr_i = 1'b0;
      for (int i = 0; i < 4; i++) push(8'h30 + 8'(i), 1'b0, 1'b0);
      m_ready_i = 1'b1;
      push(8'h20, 1'b0, 1'b0);
      chk("pp_fill", {29'd0, fill_o}, 4);
      chk("pp_ovr", {31'd0, ovr_o}, 0);
      steps(3);
      chk("pp_last", {24'd0, m_data_o}, 32'h20);
      step();
      m_ready_i = 1'b0;

      push(8'h55, 1'b0, 1'b1);
      chk("ferr_head", {31'd0, m_ferr_o}, 1);
      clr_i = 1'b1; step(); clr_i = 1'b0;
      chk("clr_valid", {31'd0, m_valid_o}, 0);
      chk("clr_fill", {29'd0, fill_o}, 0);
      chk("clr_ovr", {31'd0, ovr_o}, 0);
      step();

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) rxct_r_i = ~rxct_r_i;
         rx_data_en_i = ($urandom_range(0, 3) == 0);
         rx_data_t_i  = 10'($urandom);
         cfg_parity_i = 2'($urandom);
         m_ready_i    = ($urandom_range(0, 2) == 0);
         clr_i        = ($urandom_range(0, 63) == 0);
         rst_i        = ($urandom_range(0, 499) == 0);
         step();
      end
      rst_i = 1'b0; clr_i = 1'b0; rx_data_en_i = 1'b0;
      steps(2);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
